// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight register writes per post-ID stage,
// selects a forwarding source per source operand and flags load-use stalls.
module fwd_scoreboard #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned LOAD_RDY   = 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [4:0]            id_rd,
  input  logic                  id_we,
  input  logic                  id_is_load,
  input  logic [NSRC*5-1:0]     id_rs,
  input  logic [NSRC-1:0]       id_rs_used,
  output logic [NSRC*SEL_W-1:0] fwd_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int unsigned RW = 5;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          rdy;
  } slot_t;

  slot_t [NUM_STAGES-1:0]           slots;
  slot_t [NUM_STAGES-1:0]           slots_d;
  slot_t                            issue;
  logic  [CNT_W-1:0]                stall_cnt_d;
  logic  [NSRC-1:0][NUM_STAGES-1:0] match;
  logic  [NSRC-1:0]                 hazard;

  // Operand/slot match matrix; x0 writes are tracked but never match.
  always_comb begin
    for (int j = 0; j < int'(NSRC); j++) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        match[j][i] = slots[i].valid && (slots[i].rd != '0) &&
                      (slots[i].rd == id_rs[RW*j +: RW]) && id_rs_used[j];
      end
    end
  end

  // Youngest producer wins: scan oldest to youngest so the lowest index lands last.
  always_comb begin
    fwd_sel = '0;
    hazard  = '0;
    for (int j = 0; j < int'(NSRC); j++) begin
      for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
        if (match[j][i]) begin
          fwd_sel[SEL_W*j +: SEL_W] = SEL_W'(i + 1);
          hazard[j]                 = ~slots[i].rdy;
        end
      end
    end
  end

  assign stall = id_valid & (|hazard);

  // Entry pushed into slot 0; stalled or flushed instructions become bubbles.
  always_comb begin
    issue.valid = id_valid & id_we & ~stall & ~flush;
    issue.rd    = id_rd;
    issue.rdy   = ~id_is_load | 1'(LOAD_RDY == 0);
  end

  // Shift pipeline; a load becomes forwardable on reaching LOAD_RDY and stays so.
  always_comb begin
    slots_d = slots;
    if (adv) begin
      slots_d[0] = issue;
      for (int i = 1; i < int'(NUM_STAGES); i++) begin
        slots_d[i] = slots[i-1];
        if (i == int'(LOAD_RDY)) slots_d[i].rdy = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt;
    if (adv && stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots     <= '0;
      stall_cnt <= '0;
    end else begin
      slots     <= slots_d;
      stall_cnt <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios plus randomized traffic against an
// issue-history model, on a 3-stage instance and a 1-stage instance.
module tb_fwd_scoreboard;
  logic       clk, rst, adv, flush, id_valid, id_we, id_is_load;
  logic [4:0] id_rd;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [3:0] fwd_sel;
  logic       stall;
  logic [3:0] stall_cnt;
  logic [1:0] fwd_sel1;
  logic       stall1;
  logic [3:0] stall_cnt1;

  int total = 0;
  int bad   = 0;

  localparam int LRDY = 1;

  fwd_scoreboard #(.NUM_STAGES(3), .NSRC(2), .LOAD_RDY(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .adv(adv), .flush(flush), .id_valid(id_valid),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt));

  fwd_scoreboard #(.NUM_STAGES(1), .NSRC(2), .LOAD_RDY(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .adv(adv), .flush(flush), .id_valid(id_valid),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .fwd_sel(fwd_sel1), .stall(stall1), .stall_cnt(stall_cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: history of issued writers stamped with the advance count at issue.
  typedef struct {
    int rd;
    bit ld;
    int born;
  } ent_t;

  ent_t h0[$];
  ent_t h1[$];
  int   advs  = 0;
  int   mcnt0 = 0;
  int   mcnt1 = 0;

  function automatic void m_eval(input ent_t h[$], input int ns,
                                 output int sel0, output int sel1, output bit stl);
    int sel[2];
    stl = 1'b0;
    for (int j = 0; j < 2; j++) begin
      int rs;
      int best;
      bit bld;
      rs   = (j == 0) ? int'(id_rs[4:0]) : int'(id_rs[9:5]);
      best = -1;
      bld  = 1'b0;
      if (id_rs_used[j] && rs != 0) begin
        foreach (h[k]) begin
          int age;
          age = advs - h[k].born - 1;
          if (age < ns && h[k].rd == rs && (best < 0 || age < best)) begin
            best = age;
            bld  = h[k].ld;
          end
        end
      end
      sel[j] = best + 1;
      if (best >= 0 && bld && best < LRDY && id_valid) stl = 1'b1;
    end
    sel0 = sel[0];
    sel1 = sel[1];
  endfunction

  function automatic void m_reset();
    h0.delete();
    h1.delete();
    advs  = 0;
    mcnt0 = 0;
    mcnt1 = 0;
  endfunction

  task automatic drive(input int v, input int we, input int ld, input int rd,
                       input int r0, input int r1, input int used, input int fl, input int a);
    id_valid   = v[0];
    id_we      = we[0];
    id_is_load = ld[0];
    id_rd      = 5'(rd);
    id_rs      = {5'(r1), 5'(r0)};
    id_rs_used = 2'(used);
    flush      = fl[0];
    adv        = a[0];
  endtask

  // Advance one clock and mirror the edge into the model.
  task automatic tick();
    int   a, b;
    bit   s0, s1;
    ent_t e;
    if (rst) begin
      m_eval(h0, 3, a, b, s0);
      m_eval(h1, 1, a, b, s1);
      if (adv) begin
        e.rd   = int'(id_rd);
        e.ld   = id_is_load;
        e.born = advs;
        if (id_valid && id_we && !flush && !s0) h0.push_back(e);
        if (id_valid && id_we && !flush && !s1) h1.push_back(e);
        if (s0 && mcnt0 < 15) mcnt0++;
        if (s1 && mcnt1 < 15) mcnt1++;
        advs++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 1, 0, 5, 5, 5, 3, 0, 1);
    #1;
    total++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_main: sel=%h stall=%b cnt=%0d want 0/0/0", fwd_sel, stall, stall_cnt);
    end
    total++;
    if (fwd_sel1 !== 2'd0 || stall1 !== 1'b0 || stall_cnt1 !== 4'd0) begin
      bad++;
      $display("FAIL reset_n1: sel=%h stall=%b cnt=%0d want 0/0/0", fwd_sel1, stall1, stall_cnt1);
    end
    do_reset();
  endtask

  task automatic test_forward();
    int want[4] = '{1, 2, 3, 0};
    do_reset();
    drive(1, 1, 0, 5, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 5, 0, 1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (int'(fwd_sel[1:0]) != want[k] || stall !== 1'b0) begin
        bad++;
        $display("FAIL fwd_age%0d: sel=%0d stall=%b want sel=%0d stall=0", k, fwd_sel[1:0], stall, want[k]);
      end
      total++;
      if (int'(fwd_sel1[0]) != ((k == 0) ? 1 : 0) || stall1 !== 1'b0) begin
        bad++;
        $display("FAIL fwd_n1_age%0d: sel=%0d stall=%b want sel=%0d", k, fwd_sel1[0], stall1, (k == 0) ? 1 : 0);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 1, 7, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0, 7, 2, 0, 1);
    @(negedge clk);
    total++;
    if (fwd_sel[3:2] !== 2'd1 || stall !== 1'b1 || stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL load_use_stall: sel=%0d stall=%b cnt=%0d want 1/1/0", fwd_sel[3:2], stall, stall_cnt);
    end
    total++;
    if (fwd_sel1[1] !== 1'b1 || stall1 !== 1'b1) begin
      bad++;
      $display("FAIL load_use_n1_stall: sel=%0d stall=%b want 1/1", fwd_sel1[1], stall1);
    end
    tick();
    @(negedge clk);
    total++;
    if (fwd_sel[3:2] !== 2'd2 || stall !== 1'b0 || stall_cnt !== 4'd1) begin
      bad++;
      $display("FAIL load_use_fwd: sel=%0d stall=%b cnt=%0d want 2/0/1", fwd_sel[3:2], stall, stall_cnt);
    end
    total++;
    if (fwd_sel1 !== 2'd0 || stall1 !== 1'b0 || stall_cnt1 !== 4'd1) begin
      bad++;
      $display("FAIL load_use_n1_retired: sel=%0d stall=%b cnt=%0d want 0/0/1", fwd_sel1, stall1, stall_cnt1);
    end
    tick();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 1, 0, 3, 0, 0, 0, 0, 1);
    tick();
    drive(1, 1, 0, 3, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 3, 0, 1, 0, 1);
    @(negedge clk);
    total++;
    if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0) begin
      bad++;
      $display("FAIL youngest_alu: sel=%0d stall=%b want 1/0", fwd_sel[1:0], stall);
    end
    drive(1, 1, 0, 4, 0, 0, 0, 0, 1);
    tick();
    drive(1, 1, 1, 4, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 4, 4, 3, 0, 1);
    @(negedge clk);
    total++;
    if (fwd_sel !== 4'b0101 || stall !== 1'b1) begin
      bad++;
      $display("FAIL youngest_load: sel=%h stall=%b want 5/1", fwd_sel, stall);
    end
    tick();
  endtask

  task automatic test_freeze();
    do_reset();
    drive(1, 1, 1, 9, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 9, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (stall !== 1'b1 || stall_cnt !== 4'd0 || fwd_sel[1:0] !== 2'd1) begin
        bad++;
        $display("FAIL freeze_hold%0d: stall=%b cnt=%0d sel=%0d want 1/0/1", k, stall, stall_cnt, fwd_sel[1:0]);
      end
      tick();
    end
    adv = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || stall_cnt !== 4'd1 || fwd_sel[1:0] !== 2'd2) begin
      bad++;
      $display("FAIL freeze_release: stall=%b cnt=%0d sel=%0d want 0/1/2", stall, stall_cnt, fwd_sel[1:0]);
    end
    total++;
    if (stall1 !== 1'b0 || stall_cnt1 !== 4'd1 || fwd_sel1 !== 2'd0) begin
      bad++;
      $display("FAIL freeze_n1_release: stall=%b cnt=%0d sel=%0d want 0/1/0", stall1, stall_cnt1, fwd_sel1);
    end
    tick();
  endtask

  task automatic test_x0_flush();
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 3, 0, 1);
    @(negedge clk);
    total++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL x0_nomatch: sel=%h stall=%b want 0/0", fwd_sel, stall);
    end
    drive(1, 1, 0, 6, 0, 0, 0, 1, 1);
    tick();
    drive(1, 0, 0, 0, 6, 0, 1, 0, 1);
    @(negedge clk);
    total++;
    if (fwd_sel[1:0] !== 2'd0) begin
      bad++;
      $display("FAIL flush_bubble: sel=%0d want 0", fwd_sel[1:0]);
    end
    drive(1, 1, 1, 8, 0, 0, 0, 0, 1);
    tick();
    drive(1, 1, 0, 8, 8, 0, 1, 1, 1);
    @(negedge clk);
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL flush_stall_out: stall=%b want 1", stall);
    end
    tick();
    drive(1, 0, 0, 0, 8, 0, 1, 0, 1);
    @(negedge clk);
    total++;
    if (fwd_sel[1:0] !== 2'd2 || stall !== 1'b0 || stall_cnt !== 4'd1) begin
      bad++;
      $display("FAIL flush_stall_after: sel=%0d stall=%b cnt=%0d want 2/0/1", fwd_sel[1:0], stall, stall_cnt);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 1, 7, 0, 0, 0, 0, 1);
      tick();
      drive(1, 0, 0, 0, 7, 0, 1, 0, 1);
      tick();
      @(negedge clk);
      total++;
      if (int'(stall_cnt) != ((k + 1 > 15) ? 15 : k + 1) || stall_cnt1 !== stall_cnt) begin
        bad++;
        $display("FAIL sat_cnt%0d: cnt=%0d cnt1=%0d want %0d", k, stall_cnt, stall_cnt1, (k + 1 > 15) ? 15 : k + 1);
      end
    end
    drive(1, 1, 1, 7, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 7, 0, 1, 0, 1);
    #1;
    total++;
    if (stall !== 1'b1 || stall1 !== 1'b1) begin
      bad++;
      $display("FAIL sat_midstall: stall=%b stall1=%b want 1/1", stall, stall1);
    end
    rst = 1'b0;
    m_reset();
    #1;
    total++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || stall_cnt !== 4'd0 ||
        fwd_sel1 !== 2'd0 || stall1 !== 1'b0 || stall_cnt1 !== 4'd0) begin
      bad++;
      $display("FAIL async_reset: sel=%h stall=%b cnt=%0d sel1=%h stall1=%b cnt1=%0d want all 0",
               fwd_sel, stall, stall_cnt, fwd_sel1, stall1, stall_cnt1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || stall1 !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: sel=%h stall=%b stall1=%b want 0/0/0", fwd_sel, stall, stall1);
    end
    tick();
  endtask

  task automatic test_random();
    int e0, e1, f0, f1;
    bit es, fs;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(int'($urandom_range(0, 99) < 85), int'($urandom_range(0, 99) < 70),
            int'($urandom_range(0, 99) < 40), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 99) < 10),
            int'($urandom_range(0, 99) < 80));
      m_eval(h0, 3, e0, e1, es);
      m_eval(h1, 1, f0, f1, fs);
      @(negedge clk);
      total++;
      if (fwd_sel !== {2'(e1), 2'(e0)} || stall !== es || stall_cnt !== 4'(mcnt0)) begin
        bad++;
        $display("FAIL rand_main@%0d: sel=%h stall=%b cnt=%0d want sel=%h stall=%b cnt=%0d",
                 n, fwd_sel, stall, stall_cnt, {2'(e1), 2'(e0)}, es, mcnt0);
      end
      total++;
      if (fwd_sel1 !== {1'(f1), 1'(f0)} || stall1 !== fs || stall_cnt1 !== 4'(mcnt1)) begin
        bad++;
        $display("FAIL rand_n1@%0d: sel=%h stall=%b cnt=%0d want sel=%h stall=%b cnt=%0d",
                 n, fwd_sel1, stall1, stall_cnt1, {1'(f1), 1'(f0)}, fs, mcnt1);
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    test_reset();
    test_forward();
    test_load_use();
    test_youngest();
    test_freeze();
    test_x0_flush();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
